// File: rtl/gate_settle_pkg.sv
// Shared definitions for the gate settle/capture stage family:
// FSM state encoding and default timing constants.
package gate_settle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_HOLD   = 2'b10
    } state_e;

    localparam int DEFAULT_SETTLE = 2;
    localparam int DEFAULT_CNT_W  = 4;
    localparam int MAX_SETTLE     = 15;

endpackage

// File: rtl/gate_settle_capture_if.sv
// Bundle of the operand handshake, the gate-network drive/return
// and the result handshake of gate_settle_capture.
// The master modport is the surrounding system; the slave modport is the stage.
interface gate_settle_capture_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] net_a;
    logic [WIDTH-1:0] net_b;
    logic [WIDTH-1:0] net_c;
    logic [WIDTH-1:0] net_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_c, net_out, out_ready,
        input  in_ready, net_a, net_b, net_c, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, net_out, out_ready,
        output in_ready, net_a, net_b, net_c, out_valid, out_data, busy
    );
endinterface

// File: rtl/gate_settle_capture_settle_counter.sv
// settle_counter: loadable down-counter with zero flag. It stops at zero
// and never wraps. Reusable by any multi-cycle capture stage.
module settle_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments, so all flops see pre-edge values.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
endmodule

// File: rtl/gate_settle_capture.sv
// gate_settle_capture: launches an operand triple into an external delayed-gate
// network, waits SETTLE cycles, captures the network output and offers it on a
// valid/ready handshake.
// Optional feature macro: GATE_SETTLE_GLITCH_CHECK_EN. When it is defined,
// net_out is also sampled one cycle before capture. The out_glitch port flags
// any difference between that early sample and the captured value.
module gate_settle_capture
    import gate_settle_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = DEFAULT_SETTLE,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_settle_capture_if.slave  bus
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
    ,
    output logic                  out_glitch
`endif
);
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
    localparam int MIN_SETTLE = 2;
`else
    localparam int MIN_SETTLE = 1;
`endif

    if ((SETTLE < MIN_SETTLE) || (SETTLE > MAX_SETTLE)) begin : g_bad_settle
        $error("gate_settle_capture: SETTLE out of legal range");
    end
    if ((1 << CNT_W) <= SETTLE) begin : g_bad_cnt_w
        $error("gate_settle_capture: CNT_W too narrow for SETTLE");
    end

    state_e           state_d, state_q;
    logic [WIDTH-1:0] net_a_d, net_a_q;
    logic [WIDTH-1:0] net_b_d, net_b_q;
    logic [WIDTH-1:0] net_c_d, net_c_q;
    logic [WIDTH-1:0] out_data_d, out_data_q;
    logic             out_valid_d, out_valid_q;
    logic             busy_d, busy_q;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
    logic [WIDTH-1:0] early_d, early_q;
    logic             glitch_d, glitch_q;
`else
    logic             unused_cnt_val;
    assign unused_cnt_val = ^cnt_val;
`endif

    settle_counter #(.CNT_W(CNT_W)) u_settle_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(SETTLE - 1)),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    // Next state, launch registers, capture and counter control.
    always_comb begin
        state_d     = state_q;
        net_a_d     = net_a_q;
        net_b_d     = net_b_q;
        net_c_d     = net_c_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
        early_d     = early_q;
        glitch_d    = glitch_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    net_a_d  = bus.in_a;
                    net_b_d  = bus.in_b;
                    net_c_d  = bus.in_c;
                    cnt_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    out_data_d  = bus.net_out;
                    out_valid_d = 1'b1;
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
                    glitch_d    = (early_q != bus.net_out);
`endif
                    state_d     = ST_HOLD;
                end else begin
                    cnt_dec = 1'b1;
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
                    // One cycle before capture the count reads 1.
                    if (cnt_val == CNT_W'(1)) begin
                        early_d = bus.net_out;
                    end
`endif
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
                    glitch_d    = 1'b0;
`endif
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers, all cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            net_a_q     <= '0;
            net_b_q     <= '0;
            net_c_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
            early_q     <= '0;
            glitch_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            net_a_q     <= net_a_d;
            net_b_q     <= net_b_d;
            net_c_q     <= net_c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
            early_q     <= early_d;
            glitch_q    <= glitch_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.net_a     = net_a_q;
    assign bus.net_b     = net_b_q;
    assign bus.net_c     = net_c_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
    assign out_glitch    = glitch_q;
`endif
endmodule

// File: tb/tb_gate_settle_capture.sv
// Testbench for gate_settle_capture: a per-bit 3-input AND network with a
// programmable output delay, plus scenario tasks checked against a
// timeline/queue reference model.
module tb_gate_settle_capture;
    localparam int W = 8;
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
    localparam int S = 3;
`else
    localparam int S = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned net_delay = 6;
    int          tests_run = 0;
    int          failed = 0;

    gate_settle_capture_if #(.WIDTH(W)) ifc();
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
    logic out_glitch;
`endif

    gate_settle_capture #(.WIDTH(W), .SETTLE(S), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
        ,
        .out_glitch (out_glitch)
`endif
    );

    always #5 clk = ~clk;

    // Gate network model: each change of the inputs appears at net_out after net_delay.
    always @(ifc.net_a or ifc.net_b or ifc.net_c) begin
        fork
            begin
                automatic logic [W-1:0] v = ifc.net_a & ifc.net_b & ifc.net_c;
                #(net_delay) ifc.net_out = v;
            end
        join_none
    end

    function automatic logic [W-1:0] and3(input logic [W-1:0] a, b, c);
        return a & b & c;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [W-1:0] a, b, c);
        ifc.in_a = a;
        ifc.in_b = b;
        ifc.in_c = c;
    endtask

    task automatic test_reset();
        logic [W-1:0] a;
        tick();
        tick();
        tests_run++;
        if ({ifc.out_valid, ifc.busy} !== 2'b00) begin
            failed++;
            $display("FAIL reset_flags: got %b expected 00", {ifc.out_valid, ifc.busy});
        end
        tests_run++;
        if ({ifc.net_a, ifc.net_b, ifc.net_c, ifc.out_data} !== '0) begin
            failed++;
            $display("FAIL reset_data: got %h expected 0", {ifc.net_a, ifc.net_b, ifc.net_c, ifc.out_data});
        end
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
        tests_run++;
        if (out_glitch !== 1'b0) begin
            failed++;
            $display("FAIL reset_glitch: got %b expected 0", out_glitch);
        end
`endif
        rst = 1'b0;
        tick();
        tests_run++;
        if ({ifc.out_valid, ifc.in_ready, ifc.busy} !== 3'b010) begin
            failed++;
            $display("FAIL reset_release: got %b expected 010", {ifc.out_valid, ifc.in_ready, ifc.busy});
        end
        // Reach HOLD, then hit it with an asynchronous mid-cycle reset.
        a = W'($urandom) | W'(1);
        drive(a, a, a);
        ifc.in_valid = 1'b1;
        ifc.out_ready = 1'b0;
        tick();
        ifc.in_valid = 1'b0;
        repeat (S) tick();
        tests_run++;
        if ({ifc.out_valid, ifc.out_data} !== {1'b1, a}) begin
            failed++;
            $display("FAIL reset_pre_hold: got %b/%h expected 1/%h", ifc.out_valid, ifc.out_data, a);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({ifc.out_valid, ifc.busy} !== 2'b00) begin
            failed++;
            $display("FAIL reset_async_flags: got %b expected 00", {ifc.out_valid, ifc.busy});
        end
        tests_run++;
        if ({ifc.net_a, ifc.net_b, ifc.net_c, ifc.out_data} !== '0) begin
            failed++;
            $display("FAIL reset_async_data: got %h expected 0", {ifc.net_a, ifc.net_b, ifc.net_c, ifc.out_data});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tests_run++;
        if ({ifc.out_valid, ifc.in_ready, ifc.busy} !== 3'b010) begin
            failed++;
            $display("FAIL reset_async_release: got %b expected 010", {ifc.out_valid, ifc.in_ready, ifc.busy});
        end
    endtask

    task automatic test_basic();
        logic [2:0] exp_st;
        drive(8'hFF, 8'hF0, 8'h3C);
        ifc.in_valid = 1'b1;
        ifc.out_ready = 1'b0;
        tick();
        ifc.in_valid = 1'b0;
        tests_run++;
        if ({ifc.net_a, ifc.net_b, ifc.net_c} !== {8'hFF, 8'hF0, 8'h3C}) begin
            failed++;
            $display("FAIL basic_launch: got %h expected fff03c", {ifc.net_a, ifc.net_b, ifc.net_c});
        end
        tests_run++;
        if ({ifc.out_valid, ifc.in_ready, ifc.busy} !== 3'b001) begin
            failed++;
            $display("FAIL basic_launch_flags: got %b expected 001", {ifc.out_valid, ifc.in_ready, ifc.busy});
        end
        for (int k = 1; k <= S; k++) begin
            tick();
            exp_st = (k == S) ? 3'b101 : 3'b001;
            tests_run++;
            if ({ifc.out_valid, ifc.in_ready, ifc.busy} !== exp_st) begin
                failed++;
                $display("FAIL basic_settle_%0d: got %b expected %b", k, {ifc.out_valid, ifc.in_ready, ifc.busy}, exp_st);
            end
        end
        tests_run++;
        if (ifc.out_data !== 8'h30) begin
            failed++;
            $display("FAIL basic_data: got %h expected 30", ifc.out_data);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, c;
        a = W'($urandom);
        b = W'($urandom);
        c = W'($urandom);
        drive(a, b, c);
        ifc.in_valid = 1'b1;
        repeat (5) begin
            tick();
            tests_run++;
            if ({ifc.out_valid, ifc.in_ready, ifc.busy, ifc.out_data} !== {3'b101, 8'h30}) begin
                failed++;
                $display("FAIL bp_hold: got %b/%h expected 101/30", {ifc.out_valid, ifc.in_ready, ifc.busy}, ifc.out_data);
            end
            tests_run++;
            if ({ifc.net_a, ifc.net_b, ifc.net_c} !== {8'hFF, 8'hF0, 8'h3C}) begin
                failed++;
                $display("FAIL bp_no_relaunch: got %h expected fff03c", {ifc.net_a, ifc.net_b, ifc.net_c});
            end
        end
        ifc.out_ready = 1'b1;
        tick();
        tests_run++;
        if ({ifc.out_valid, ifc.in_ready, ifc.busy} !== 3'b010) begin
            failed++;
            $display("FAIL bp_release: got %b expected 010", {ifc.out_valid, ifc.in_ready, ifc.busy});
        end
        tick();
        ifc.in_valid = 1'b0;
        tests_run++;
        if ({ifc.net_a, ifc.net_b, ifc.net_c} !== {a, b, c}) begin
            failed++;
            $display("FAIL bp_resume_launch: got %h expected %h", {ifc.net_a, ifc.net_b, ifc.net_c}, {a, b, c});
        end
        repeat (S) tick();
        tests_run++;
        if ({ifc.out_valid, ifc.out_data} !== {1'b1, and3(a, b, c)}) begin
            failed++;
            $display("FAIL bp_resume_result: got %b/%h expected 1/%h", ifc.out_valid, ifc.out_data, and3(a, b, c));
        end
        tick();
    endtask

    task automatic test_reset_mid_settle();
        logic [W-1:0] a, b, c;
        ifc.out_ready = 1'b1;
        drive(W'($urandom), W'($urandom), W'($urandom));
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if ({ifc.busy, ifc.net_a, ifc.net_b, ifc.net_c} !== '0) begin
            failed++;
            $display("FAIL mid_reset_clear: got %h expected 0", {ifc.busy, ifc.net_a, ifc.net_b, ifc.net_c});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < S + 4; i++) begin
            tick();
            tests_run++;
            if (ifc.out_valid !== 1'b0) begin
                failed++;
                $display("FAIL mid_reset_no_valid_%0d: got %b expected 0", i, ifc.out_valid);
            end
        end
        a = W'($urandom);
        b = W'($urandom);
        c = W'($urandom);
        drive(a, b, c);
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        repeat (S) tick();
        tests_run++;
        if ({ifc.out_valid, ifc.out_data} !== {1'b1, and3(a, b, c)}) begin
            failed++;
            $display("FAIL mid_reset_next: got %b/%h expected 1/%h", ifc.out_valid, ifc.out_data, and3(a, b, c));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ops_a[4], ops_b[4], ops_c[4];
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp_d;
        logic [2:0]   exp_st;
        int           next, p, k;
        for (int i = 0; i < 4; i++) begin
            ops_a[i] = W'($urandom);
            ops_b[i] = W'($urandom);
            ops_c[i] = W'($urandom);
        end
        ifc.out_ready = 1'b1;
        drive(ops_a[0], ops_b[0], ops_c[0]);
        exp_q.push_back(and3(ops_a[0], ops_b[0], ops_c[0]));
        ifc.in_valid = 1'b1;
        next = 1;
        // Accept k lands on edge k*(S+2); its result is valid on edge k*(S+2)+S.
        for (int e = 0; e < 4 * (S + 2); e++) begin
            tick();
            p = e % (S + 2);
            k = e / (S + 2);
            exp_st = {p == S, p == S + 1, p <= S};
            tests_run++;
            if ({ifc.out_valid, ifc.in_ready, ifc.busy} !== exp_st) begin
                failed++;
                $display("FAIL b2b_flags_e%0d: got %b expected %b", e, {ifc.out_valid, ifc.in_ready, ifc.busy}, exp_st);
            end
            if (p == 0) begin
                tests_run++;
                if ({ifc.net_a, ifc.net_b, ifc.net_c} !== {ops_a[k], ops_b[k], ops_c[k]}) begin
                    failed++;
                    $display("FAIL b2b_launch_%0d: got %h expected %h", k, {ifc.net_a, ifc.net_b, ifc.net_c}, {ops_a[k], ops_b[k], ops_c[k]});
                end
                if (next < 4) begin
                    drive(ops_a[next], ops_b[next], ops_c[next]);
                    exp_q.push_back(and3(ops_a[next], ops_b[next], ops_c[next]));
                    next++;
                end else begin
                    ifc.in_valid = 1'b0;
                end
            end
            if (p == S) begin
                exp_d = exp_q.pop_front();
                tests_run++;
                if (ifc.out_data !== exp_d) begin
                    failed++;
                    $display("FAIL b2b_result_%0d: got %h expected %h", k, ifc.out_data, exp_d);
                end
            end
        end
    endtask

`ifdef GATE_SETTLE_GLITCH_CHECK_EN
    task automatic test_glitch();
        logic [W-1:0] a;
        // Settle the network to zero first so the next change is visible.
        net_delay = 6;
        ifc.out_ready = 1'b0;
        drive('0, '0, '0);
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        repeat (S) tick();
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        // Slow network: 2.5 cycles, early sample still sees the old value.
        net_delay = 25;
        a = W'($urandom) | W'(1);
        drive(a, a, a);
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        repeat (S) tick();
        tests_run++;
        if ({ifc.out_valid, out_glitch, ifc.out_data} !== {2'b11, a}) begin
            failed++;
            $display("FAIL glitch_slow: got %b%b/%h expected 11/%h", ifc.out_valid, out_glitch, ifc.out_data, a);
        end
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        tests_run++;
        if ({ifc.out_valid, out_glitch} !== 2'b00) begin
            failed++;
            $display("FAIL glitch_clear: got %b expected 00", {ifc.out_valid, out_glitch});
        end
        // One-cycle network: settled before the early sample.
        net_delay = 10;
        drive(~a, ~a, ~a);
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        repeat (S) tick();
        tests_run++;
        if ({ifc.out_valid, out_glitch, ifc.out_data} !== {2'b10, ~a}) begin
            failed++;
            $display("FAIL glitch_fast: got %b%b/%h expected 10/%h", ifc.out_valid, out_glitch, ifc.out_data, ~a);
        end
        ifc.out_ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.net_out   = '0;
        drive('0, '0, '0);
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_settle();
        test_back_to_back();
`ifdef GATE_SETTLE_GLITCH_CHECK_EN
        test_glitch();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule

// File: doc/gate_settle_capture.md
# gate_settle_capture

Multi-cycle launch/capture stage sitting directly downstream of the team's delayed-gate networks (banks of 3-input delayed AND gates, `D` = 6 ns per gate). It registers three WIDTH-bit operand vectors onto the network inputs. It then waits a programmable number of clock cycles for the gate delays to settle, captures the network output, and presents it on a valid/ready handshake. This lets synchronous logic consume deliberately slow gate-level logic without sampling mid-transition.

## Interface
- `WIDTH`, 8: number of parallel gate lanes (one 3-input gate per bit).
- `SETTLE`, 2: clock cycles between launch and capture; legal range 1..15 (2..15 with glitch check).
- `CNT_W`, 4: settle counter width; must satisfy 2^CNT_W > SETTLE.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operand triple present.
- `in_ready`  out  1: stage can accept operands.
- `in_a`, `in_b`, `in_c`  in  WIDTH each: operand vectors.
- `net_a`, `net_b`, `net_c`  out  WIDTH each: registered drive to gate network inputs.
- `net_out`  in  WIDTH: gate network output (combinational, delayed).
- `out_valid`  out  1: captured result available.
- `out_ready`  in  1: consumer accepts result.
- `out_data`  out  WIDTH: captured result.
- `busy`  out  1: high in SETTLE or HOLD.
- `out_glitch`  out  1: present only with GLITCH_CHECK_EN.

## Operation
- FSM states: IDLE, SETTLE, HOLD.
- IDLE: `in_ready`=1. If `in_valid`, load `in_a/b/c` into `net_a/b/c` registers, counter←SETTLE−1, go to SETTLE.
- SETTLE: `net_*` held constant. Counter decrements each cycle. When counter = 0, capture `net_out` into `out_data`, set `out_valid`, go to HOLD.
- HOLD: `out_data` and `net_*` held. If `out_ready`, clear `out_valid` and go to IDLE. A new operand is not accepted in the same cycle.
- `in_ready` is 1 only in IDLE. `in_valid` in SETTLE or HOLD is ignored, and the upstream stage must hold it.
- `out_valid` is never withdrawn without `out_ready`. `out_data` is stable while `out_valid` is 1.
- No arithmetic beyond the counter. The counter never wraps; it stops at 0.
- Reset (any state, including mid-SETTLE) forces IDLE. Reset values: `net_*`=0, `out_data`=0, `out_valid`=0, `busy`=0, `in_ready`=1 (after reset is released), `out_glitch`=0, counter=0.

## Timing
- Launch: accept at rising edge t. `net_*` are updated at t.
- Capture at edge t+SETTLE. `out_valid` is high from t+SETTLE.
- Earliest next accept is at edge t+SETTLE+2, given `out_ready` is held high.
- Peak throughput is one result per SETTLE+2 cycles.
- SETTLE must cover the network depth × 6 ns plus setup within SETTLE clock periods; the integrator sets it.
- `busy` = (state ≠ IDLE), registered.

## Configuration
- `GATE_SETTLE_GLITCH_CHECK_EN` defined:
  - Also sample `net_out` at edge t+SETTLE−1.
  - At capture, `out_glitch` = (early sample ≠ final sample). It is held with `out_data` and cleared on handshake or reset.
  - SETTLE ≥ 2 is required; elaboration error otherwise.
- Undefined: no early sample register and no `out_glitch` port. SETTLE ≥ 1.

## Structure
- Shared package `gate_settle_pkg`:
  - state enum (IDLE=2'b00, SETTLE=2'b01, HOLD=2'b10);
  - default SETTLE/CNT_W constants.
- Sub-module `settle_counter`:
  - load / decrement / zero-flag down-counter, CNT_W wide, async active-high reset;
  - reusable by other capture stages.
- Gate networks are instantiated outside this block, by the integrator.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → immediately `out_valid`=0, `net_*`=0, `busy`=0; `in_ready`=1 after release.
- Basic: SETTLE=2, network = per-bit 3-input AND, drive a=8'hFF, b=8'hF0, c=8'h3C accepted at t → `out_data`=8'h30, `out_valid` rising at t+2.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid` asserted and new operands → `out_data` stays 8'h30, `in_ready`=0, no second launch; accept resumes at IDLE.
- Reset mid-SETTLE: accept an operand, assert `rst` at t+1 → no `out_valid` ever appears for that operand; the next operand completes normally.
- Back-to-back: `out_ready`=1 constantly, 4 operands streamed → results in order, spaced SETTLE+2=4 cycles apart.
- Glitch (with `GATE_SETTLE_GLITCH_CHECK_EN`, SETTLE=3): network model delays output by 2.5 cycles → `out_glitch`=1. Delay of 1 cycle → `out_glitch`=0.
